// File: rtl/card_dealer_if.sv
// Card encoding types and the request/response bundle between the game FSM and card_dealer.
package card_dealer_pkg;
    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned RANKS     = 13;
    localparam int unsigned IDX_W     = 6;

    typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;
    typedef enum logic [3:0] {
        TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE, TEN, JACK, QUEEN, KING, ACE
    } rank_t;

    typedef struct packed {
        suit_t suit;
        rank_t rank;
    } card_t;
endpackage

interface card_dealer_if;
    import card_dealer_pkg::*;

    logic             new_deck;
    logic             draw_req;
    card_t            card;
    logic             card_valid;
    logic             busy;
    logic             deck_empty;
    logic             draw_err;
    logic [IDX_W-1:0] cards_dealt;

    modport master (
        output new_deck, draw_req,
        input  card, card_valid, busy, deck_empty, draw_err, cards_dealt
    );

    modport slave (
        input  new_deck, draw_req,
        output card, card_valid, busy, deck_empty, draw_err, cards_dealt
    );
endinterface

// File: rtl/card_dealer.sv
// Draw-without-replacement card dealer: random LFSR picks with a bounded
// retry count, then a linear scan guaranteeing termination.
module card_dealer
    import card_dealer_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_TRIES = 15
) (
    input  logic        clk,
    input  logic        reset,
    card_dealer_if.slave bus
);
    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int unsigned PAD_W = (2 ** IDX_W) - DECK_SIZE;
    localparam logic [15:0] POLY  = 16'hB400;
    localparam logic [IDX_W-1:0] DECK_N   = IDX_W'(DECK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, PICK, SCAN} state_t;

    state_t                 state_q;
    logic [15:0]            lfsr_q;
    logic [15:0]            lfsr_d;
    logic [DECK_SIZE-1:0]   used_q;
    logic [2**IDX_W-1:0]    used_ext;
    logic [TRY_W-1:0]       tries_q;
    logic [IDX_W-1:0]       scan_idx_q;
    logic [IDX_W-1:0]       cards_dealt_q;
    card_t                  card_q;
    logic                   card_valid_q;
    logic                   busy_q;
    logic                   draw_err_q;

    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       cand_wrap;
    logic [IDX_W-1:0]       take_idx;
    logic                   cand_ok;
    logic                   take;
    logic                   deck_empty_c;

    function automatic card_t idx_to_card(input logic [IDX_W-1:0] idx);
        card_t       c;
        int unsigned i;
        i      = 32'(idx);
        c.suit = suit_t'(2'(i / RANKS));
        c.rank = rank_t'(4'(i % RANKS));
        return c;
    endfunction

    // Right-shifting Galois LFSR, free-running in every state.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY : 16'h0000);

    // Padding the bitmap to a power of two lets out-of-range candidates index safely.
    assign used_ext  = {{PAD_W{1'b0}}, used_q};
    assign cand      = lfsr_q[IDX_W-1:0];
    assign cand_ok   = (cand < DECK_N) && !used_ext[cand];
    assign cand_wrap = (cand < DECK_N) ? cand : cand - DECK_N;
    assign take      = ((state_q == PICK) && cand_ok) ||
                       ((state_q == SCAN) && !used_ext[scan_idx_q]);
    assign take_idx  = (state_q == PICK) ? cand : scan_idx_q;

    assign deck_empty_c = (cards_dealt_q == DECK_N);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            used_q        <= '0;
            tries_q       <= '0;
            scan_idx_q    <= '0;
            cards_dealt_q <= '0;
            card_q        <= card_t'('0);
            card_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            draw_err_q    <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            card_valid_q <= 1'b0;
            draw_err_q   <= 1'b0;
            if (bus.new_deck) begin
                used_q        <= '0;
                cards_dealt_q <= '0;
                state_q       <= IDLE;
                busy_q        <= 1'b0;
            end else if (take) begin
                used_q[take_idx] <= 1'b1;
                cards_dealt_q    <= cards_dealt_q + 1'b1;
                card_q           <= idx_to_card(take_idx);
                card_valid_q     <= 1'b1;
                busy_q           <= 1'b0;
                state_q          <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.draw_req) begin
                            if (deck_empty_c) begin
                                draw_err_q <= 1'b1;
                            end else begin
                                tries_q <= '0;
                                busy_q  <= 1'b1;
                                state_q <= PICK;
                            end
                        end
                    end
                    PICK: begin
                        if (tries_q == LAST_TRY) begin
                            scan_idx_q <= cand_wrap;
                            state_q    <= SCAN;
                        end else begin
                            tries_q <= tries_q + 1'b1;
                        end
                    end
                    SCAN: begin
                        scan_idx_q <= (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.card        = card_q;
    assign bus.card_valid  = card_valid_q;
    assign bus.busy        = busy_q;
    assign bus.draw_err    = draw_err_q;
    assign bus.cards_dealt = cards_dealt_q;
    assign bus.deck_empty  = deck_empty_c;
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: a cycle table from reset plus draw sequences
// checked against a transaction-level pick/scan predictor.
`timescale 1ns/1ps
module tb_card_dealer;
    import card_dealer_pkg::*;

    localparam int unsigned MT0  = 15;
    localparam int unsigned MT1  = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sel   = 1'b0;
    logic dreq  = 1'b0;
    logic ndeck = 1'b0;

    always #5 clk = ~clk;

    card_dealer_if if0 ();
    card_dealer_if if1 ();

    card_dealer #(.SEED(SEED), .MAX_TRIES(MT0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    card_dealer #(.SEED(SEED), .MAX_TRIES(MT1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    assign if0.draw_req = dreq  & ~sel;
    assign if0.new_deck = ndeck & ~sel;
    assign if1.draw_req = dreq  &  sel;
    assign if1.new_deck = ndeck &  sel;

    logic       cv_m, busy_m, err_m, empty_m;
    logic [5:0] dealt_m;
    card_t      card_m;
    assign cv_m    = sel ? if1.card_valid  : if0.card_valid;
    assign busy_m  = sel ? if1.busy        : if0.busy;
    assign err_m   = sel ? if1.draw_err    : if0.draw_err;
    assign empty_m = sel ? if1.deck_empty  : if0.deck_empty;
    assign dealt_m = sel ? if1.cards_dealt : if0.cards_dealt;
    assign card_m  = sel ? if1.card        : if0.card;

    int n_vec = 0;
    int n_err = 0;

    logic [51:0] m_used;
    int          m_dealt;

    function automatic logic [15:0] step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR, reset and advanced alongside the DUTs.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= step(m_lfsr);
    end

    function automatic logic [5:0] idx2card(input int i);
        logic [1:0] s;
        logic [3:0] r;
        s = 2'(i / 13);
        r = 4'(i % 13);
        return {s, r};
    endfunction

    // l0 is the LFSR value seen by the first pick; returns chosen index and request-to-card latency.
    function automatic void predict(input logic [15:0] l0, input logic [51:0] used,
                                    input int mt, output int idx, output int lat);
        logic [15:0] x;
        int c;
        int s;
        x = l0; idx = -1; lat = 0; s = 0;
        for (int t = 0; t < mt; t++) begin
            c = int'(x[5:0]);
            if (c < 52 && !used[c]) begin
                idx = c; lat = t + 2;
                return;
            end
            s = (c >= 52) ? c - 52 : c;
            x = step(x);
        end
        for (int k = 0; k < 52; k++) begin
            c = (s + k) % 52;
            if (!used[c]) begin
                idx = c; lat = mt + 2 + k;
                return;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_card_valid", cv_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_draw_err", err_m, 0);
        chk("rst_cards_dealt", dealt_m, 0);
        chk("rst_deck_empty", empty_m, 0);
        chk("rst_card", card_m, 0);
        chk("rst_lfsr0", u_dut0.lfsr_q, 32'hACE1);
        chk("rst_lfsr1", u_dut1.lfsr_q, 32'hACE1);
        @(negedge clk);
        reset   = 1'b0;
        m_used  = '0;
        m_dealt = 0;
    endtask

    // Starts a request immediately; returns at #1 after the card_valid edge.
    task automatic do_draw(input int mt, input bit ign, output int got_idx);
        int          exp_idx, exp_lat, lat, gi;
        bit          got, err_seen;
        logic [5:0]  cb;
        dreq = 1'b1;
        @(posedge clk); #1;
        dreq = 1'b0;
        predict(m_lfsr, m_used, mt, exp_idx, exp_lat);
        chk("busy_after_accept", busy_m, 1);
        lat = 1; got = 0; err_seen = 0; got_idx = -1;
        while (!got && lat < 100) begin
            if (ign && lat == 1 && busy_m) dreq = 1'b1;
            @(posedge clk); #1;
            dreq = 1'b0;
            lat++;
            if (err_m) err_seen = 1;
            if (cv_m)  got = 1;
        end
        chk("draw_timeout", 32'(got), 1);
        chk("no_draw_err", 32'(err_seen), 0);
        if (got) begin
            cb = card_m;
            gi = int'(cb[5:4]) * 13 + int'(cb[3:0]);
            got_idx = gi;
            chk("latency", lat, exp_lat);
            chk("latency_in_range", 32'((lat >= 2) && (lat <= 69)), 1);
            chk("card", cb, idx2card(exp_idx));
            chk("distinct", 32'((gi < 52) ? !m_used[gi] : 1'b0), 1);
            if (exp_idx >= 0) m_used[exp_idx] = 1'b1;
            m_dealt++;
            chk("cards_dealt", dealt_m, m_dealt);
            chk("deck_empty", empty_m, 32'(m_dealt == 52));
            chk("busy_falls", busy_m, 0);
        end
    endtask

    typedef struct {
        logic nd;
        logic dr;
        logic busy;
        logic cv;
        logic err;
        int   dealt;
        int   exp_idx;
    } vec_t;

    vec_t vecs[10];
    int   seq_a[52];
    int   seq_b[52];

    initial begin
        int gi;
        // From SEED the picks see lfsr[5:0] = 56 (rejected), 28, then 39.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 28};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, -1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 39};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1};

        m_used  = '0;
        m_dealt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            ndeck = vecs[i].nd;
            dreq  = vecs[i].dr;
            @(posedge clk); #1;
            ndeck = 1'b0;
            dreq  = 1'b0;
            chk($sformatf("v%0d_busy", i), busy_m, vecs[i].busy);
            chk($sformatf("v%0d_card_valid", i), cv_m, vecs[i].cv);
            chk($sformatf("v%0d_draw_err", i), err_m, vecs[i].err);
            chk($sformatf("v%0d_cards_dealt", i), dealt_m, vecs[i].dealt);
            chk($sformatf("v%0d_deck_empty", i), empty_m, 0);
            if (vecs[i].exp_idx >= 0)
                chk($sformatf("v%0d_card", i), card_m, idx2card(vecs[i].exp_idx));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a draw.
        dreq = 1'b1;
        @(posedge clk); #1;
        dreq = 1'b0;
        chk("busy_before_reset", busy_m, 1);
        do_reset();

        for (int i = 0; i < 52; i++) begin
            if (i % 5 == 4) repeat (i % 3) @(negedge clk);
            do_draw(MT0, (i % 2) == 0, gi);
            seq_a[i] = gi;
        end

        // Request against an empty deck.
        @(negedge clk);
        dreq = 1'b1;
        @(posedge clk); #1;
        dreq = 1'b0;
        chk("empty_draw_err", err_m, 1);
        chk("empty_no_card", cv_m, 0);
        chk("empty_dealt", dealt_m, 52);
        chk("empty_flag", empty_m, 1);
        @(posedge clk); #1;
        chk("empty_err_pulse", err_m, 0);
        chk("empty_no_card2", cv_m, 0);

        // Same schedule after a second reset must replay the same deal.
        do_reset();
        for (int i = 0; i < 52; i++) begin
            if (i % 5 == 4) repeat (i % 3) @(negedge clk);
            do_draw(MT0, (i % 2) == 0, gi);
            seq_b[i] = gi;
        end
        for (int i = 0; i < 52; i++) chk($sformatf("repro_%0d", i), seq_b[i], seq_a[i]);

        // Abort a draw in flight with new_deck after 10 cards.
        @(negedge clk);
        ndeck = 1'b1;
        @(posedge clk); #1;
        ndeck = 1'b0;
        m_used = '0; m_dealt = 0;
        chk("newdeck_dealt", dealt_m, 0);
        chk("newdeck_empty", empty_m, 0);
        for (int i = 0; i < 10; i++) do_draw(MT0, 1'b0, gi);
        @(negedge clk);
        dreq = 1'b1;
        @(posedge clk); #1;
        dreq = 1'b0;
        chk("abort_busy_before", busy_m, 1);
        ndeck = 1'b1;
        @(posedge clk); #1;
        ndeck = 1'b0;
        m_used = '0; m_dealt = 0;
        chk("abort_no_card", cv_m, 0);
        chk("abort_busy", busy_m, 0);
        chk("abort_dealt", dealt_m, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_quiet", cv_m, 0);
        end
        for (int i = 0; i < 52; i++) do_draw(MT0, 1'b0, gi);

        // Instance with a single random try relies almost entirely on the scan.
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 52; i++) do_draw(MT1, (i % 3) == 0, gi);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
